snax_tcdm_responder: RTL and testbench

SNAX_TCDM_RESPONDER -- requirements
Module: snax_tcdm_responder

---
 rtl/snax_tcdm_responder.sv | 155 +++++++++++++++
 tb/tb_snax_tcdm_responder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/snax_tcdm_responder.sv
// SNAX TCDM responder: word-interleaved banked scratchpad with per-bank round-robin arbitration
// and one-cycle read latency. Define SNAX_TCDM_RSP_CONFLICT_CNT_EN to add the stall counter.
module snax_tcdm_responder #(
    parameter int DataWidth     = 64,
    parameter int SnaxTcdmPorts = 16,
    parameter int TCDMAddrWidth = 48,
    parameter int NumBanks      = 32,
    parameter int BankDepth     = 512
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
`ifdef SNAX_TCDM_RSP_CONFLICT_CNT_EN
    input  logic                     conflict_cnt_clr_i,
    output logic [31:0]              conflict_cnt_o,
`endif
    input  logic [SnaxTcdmPorts-1:0] tcdm_req_write_i,
    input  logic [TCDMAddrWidth-1:0] tcdm_req_addr_i [SnaxTcdmPorts],
    input  logic [DataWidth-1:0]     tcdm_req_data_i [SnaxTcdmPorts],
    input  logic [DataWidth/8-1:0]   tcdm_req_strb_i [SnaxTcdmPorts],
    input  logic [SnaxTcdmPorts-1:0] tcdm_req_q_valid_i,
    output logic [SnaxTcdmPorts-1:0] tcdm_rsp_q_ready_o,
    output logic [SnaxTcdmPorts-1:0] tcdm_rsp_p_valid_o,
    output logic [DataWidth-1:0]     tcdm_rsp_data_o [SnaxTcdmPorts]
);

    localparam int StrbWidth = DataWidth / 8;
    localparam int OffBits   = $clog2(StrbWidth);
    localparam int BankBits  = $clog2(NumBanks);
    localparam int RowBits   = $clog2(BankDepth);
    localparam int PortBits  = $clog2(SnaxTcdmPorts);
    localparam int UsedBits  = OffBits + BankBits + RowBits;

    logic [BankBits-1:0]  bank_sel [SnaxTcdmPorts];
    logic [RowBits-1:0]   row_sel  [SnaxTcdmPorts];
    logic [PortBits-1:0]  rr_ptr   [NumBanks];
    logic [NumBanks-1:0]  gnt_valid;
    logic [PortBits-1:0]  gnt_port [NumBanks];
    logic [DataWidth-1:0] mem      [NumBanks][BankDepth];
    logic                 unused_addr_bits;

    // Byte offset and bits above the row field are dropped, so far addresses alias onto the array.
    always_comb begin
        unused_addr_bits = 1'b0;
        for (int p = 0; p < SnaxTcdmPorts; p++) begin
            bank_sel[p] = tcdm_req_addr_i[p][OffBits +: BankBits];
            row_sel[p]  = tcdm_req_addr_i[p][OffBits+BankBits +: RowBits];
            unused_addr_bits = unused_addr_bits
                             ^ (^tcdm_req_addr_i[p][OffBits-1:0])
                             ^ (^tcdm_req_addr_i[p][TCDMAddrWidth-1:UsedBits]);
        end
    end

    always_comb begin
        int   idx;
        logic found;
        idx   = 0;
        found = 1'b0;
        for (int b = 0; b < NumBanks; b++) begin
            found        = 1'b0;
            gnt_valid[b] = 1'b0;
            gnt_port[b]  = '0;
            for (int k = 0; k < SnaxTcdmPorts; k++) begin
                idx = (int'(rr_ptr[b]) + k) % SnaxTcdmPorts;
                if (!found && rst_ni && tcdm_req_q_valid_i[idx]
                    && bank_sel[idx] == BankBits'(b)) begin
                    found        = 1'b1;
                    gnt_valid[b] = 1'b1;
                    gnt_port[b]  = PortBits'(idx);
                end
            end
        end
    end

    always_comb begin
        tcdm_rsp_q_ready_o = '0;
        for (int p = 0; p < SnaxTcdmPorts; p++) begin
            tcdm_rsp_q_ready_o[p] = gnt_valid[bank_sel[p]]
                                  && gnt_port[bank_sel[p]] == PortBits'(p);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int b = 0; b < NumBanks; b++) begin
                rr_ptr[b] <= '0;
            end
        end else begin
            for (int b = 0; b < NumBanks; b++) begin
                if (gnt_valid[b]) begin
                    rr_ptr[b] <= (gnt_port[b] == PortBits'(SnaxTcdmPorts-1))
                               ? '0 : gnt_port[b] + PortBits'(1);
                end
            end
        end
    end

    // Storage is deliberately not reset so contents survive a reset pulse.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < NumBanks; b++) begin
            if (gnt_valid[b] && tcdm_req_write_i[gnt_port[b]]) begin
                for (int j = 0; j < StrbWidth; j++) begin
                    if (tcdm_req_strb_i[gnt_port[b]][j]) begin
                        mem[b][row_sel[gnt_port[b]]][8*j +: 8] <=
                            tcdm_req_data_i[gnt_port[b]][8*j +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tcdm_rsp_p_valid_o <= '0;
            for (int p = 0; p < SnaxTcdmPorts; p++) begin
                tcdm_rsp_data_o[p] <= '0;
            end
        end else begin
            for (int p = 0; p < SnaxTcdmPorts; p++) begin
                tcdm_rsp_p_valid_o[p] <= tcdm_rsp_q_ready_o[p] && !tcdm_req_write_i[p];
                if (tcdm_rsp_q_ready_o[p] && !tcdm_req_write_i[p]) begin
                    tcdm_rsp_data_o[p] <= mem[bank_sel[p]][row_sel[p]];
                end
            end
        end
    end

`ifdef SNAX_TCDM_RSP_CONFLICT_CNT_EN
    localparam int CntBits = $clog2(SnaxTcdmPorts + 1);

    logic [CntBits-1:0] stall_cnt;
    logic [32:0]        cnt_sum;

    always_comb begin
        stall_cnt = '0;
        for (int p = 0; p < SnaxTcdmPorts; p++) begin
            stall_cnt = stall_cnt
                      + CntBits'(tcdm_req_q_valid_i[p] && !tcdm_rsp_q_ready_o[p]);
        end
        cnt_sum = {1'b0, conflict_cnt_o} + 33'(stall_cnt);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            conflict_cnt_o <= '0;
        end else if (conflict_cnt_clr_i) begin
            conflict_cnt_o <= '0;
        end else if (cnt_sum[32]) begin
            conflict_cnt_o <= '1;
        end else begin
            conflict_cnt_o <= cnt_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_snax_tcdm_responder.sv
// Directed self-checking bench for snax_tcdm_responder; conflict counter checks are
// enabled when SNAX_TCDM_RSP_CONFLICT_CNT_EN is defined.
module tb_snax_tcdm_responder;

    localparam int DW = 64;
    localparam int NP = 16;
    localparam int AW = 48;

    logic          clk;
    logic          rst_n;
    logic [NP-1:0] req_write;
    logic [AW-1:0] req_addr [NP];
    logic [DW-1:0] req_data [NP];
    logic [7:0]    req_strb [NP];
    logic [NP-1:0] req_valid;
    logic [NP-1:0] q_ready;
    logic [NP-1:0] p_valid;
    logic [DW-1:0] rsp_data [NP];
`ifdef SNAX_TCDM_RSP_CONFLICT_CNT_EN
    logic          cnt_clr;
    logic [31:0]   cnt;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    snax_tcdm_responder dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
`ifdef SNAX_TCDM_RSP_CONFLICT_CNT_EN
        .conflict_cnt_clr_i (cnt_clr),
        .conflict_cnt_o     (cnt),
`endif
        .tcdm_req_write_i   (req_write),
        .tcdm_req_addr_i    (req_addr),
        .tcdm_req_data_i    (req_data),
        .tcdm_req_strb_i    (req_strb),
        .tcdm_req_q_valid_i (req_valid),
        .tcdm_rsp_q_ready_o (q_ready),
        .tcdm_rsp_p_valid_o (p_valid),
        .tcdm_rsp_data_o    (rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic idle_all();
        req_valid = '0;
        req_write = '0;
        for (int p = 0; p < NP; p++) begin
            req_addr[p] = '0;
            req_data[p] = '0;
            req_strb[p] = '0;
        end
    endtask

    task automatic applyStimulus(input int port, input logic wr, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] data, input logic [7:0] strb);
        req_valid[port] = 1'b1;
        req_write[port] = wr;
        req_addr[port]  = addr;
        req_data[port]  = data;
        req_strb[port]  = strb;
    endtask

    task automatic single_write(input int port, input logic [AW-1:0] addr,
                                input logic [DW-1:0] data, input logic [7:0] strb,
                                input string tag);
        @(negedge clk);
        applyStimulus(port, 1'b1, addr, data, strb);
        #1 checkOutput({tag, "_rdy"}, 64'(q_ready[port]), 64'h1);
        @(negedge clk);
        idle_all();
        checkOutput({tag, "_nopv"}, 64'(p_valid[port]), 64'h0);
    endtask

    task automatic single_read(input int port, input logic [AW-1:0] addr,
                               input logic [DW-1:0] expected, input string tag);
        @(negedge clk);
        applyStimulus(port, 1'b0, addr, '0, '0);
        #1 checkOutput({tag, "_rdy"}, 64'(q_ready[port]), 64'h1);
        @(negedge clk);
        idle_all();
        checkOutput({tag, "_pv"}, 64'(p_valid[port]), 64'h1);
        checkOutput({tag, "_data"}, rsp_data[port], expected);
    endtask

    initial begin
        rst_n = 1'b0;
        idle_all();
`ifdef SNAX_TCDM_RSP_CONFLICT_CNT_EN
        cnt_clr = 1'b0;
`endif
        // A request held during reset must not be accepted.
        applyStimulus(0, 1'b0, 48'h0, '0, '0);
        repeat (2) @(negedge clk);
        checkOutput("rst_q_ready", 64'(q_ready), 64'h0);
        checkOutput("rst_p_valid", 64'(p_valid), 64'h0);
        checkOutput("rst_data0", rsp_data[0], 64'h0);
`ifdef SNAX_TCDM_RSP_CONFLICT_CNT_EN
        checkOutput("rst_cnt", 64'(cnt), 64'h0);
`endif
        idle_all();
        rst_n = 1'b1;

        // Bank 0 conflict: port 0 wins first, port 1 stalls one cycle.
        @(negedge clk);
        applyStimulus(0, 1'b0, 48'h0, '0, '0);
        applyStimulus(1, 1'b0, 48'h100, '0, '0);
        #1 checkOutput("conf_rdy_c0", 64'(q_ready), 64'h0001);
        @(negedge clk);
        checkOutput("conf_pv_c0", 64'(p_valid), 64'h0001);
        req_valid[0] = 1'b0;
        #1 checkOutput("conf_rdy_c1", 64'(q_ready), 64'h0002);
        @(negedge clk);
        checkOutput("conf_pv_c1", 64'(p_valid), 64'h0002);
        idle_all();
`ifdef SNAX_TCDM_RSP_CONFLICT_CNT_EN
        checkOutput("conf_cnt", 64'(cnt), 64'h1);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        checkOutput("conf_cnt_clr", 64'(cnt), 64'h0);
`endif

        single_write(0, 48'h0, 64'hDEADBEEF_01234567, 8'hFF, "wr0");
        single_read(0, 48'h0, 64'hDEADBEEF_01234567, "rd0");
        @(negedge clk);
        checkOutput("hold_pv", 64'(p_valid[0]), 64'h0);
        checkOutput("hold_data", rsp_data[0], 64'hDEADBEEF_01234567);

        // Different banks are served in the same cycle.
        applyStimulus(0, 1'b0, 48'h0, '0, '0);
        applyStimulus(1, 1'b0, 48'h8, '0, '0);
        #1 checkOutput("par_rdy", 64'(q_ready), 64'h0003);
        @(negedge clk);
        idle_all();
        checkOutput("par_pv", 64'(p_valid), 64'h0003);
        checkOutput("par_data0", rsp_data[0], 64'hDEADBEEF_01234567);

        single_write(0, 48'h0, 64'h0, 8'hFF, "strb_clr");
        single_write(0, 48'h0, 64'hFFFFFFFF_FFFFFFFF, 8'h0F, "strb_lo");
        single_read(0, 48'h0, 64'h00000000_FFFFFFFF, "strb_rd");
        single_write(0, 48'h0, 64'h12345678_9ABCDEF0, 8'h00, "strb_none");
        single_read(0, 48'h0, 64'h00000000_FFFFFFFF, "strb_none_rd");

        single_write(2, 48'h20000, 64'h55, 8'hFF, "wrap_wr");
        single_read(3, 48'h0, 64'h55, "wrap_rd");

        // Back-to-back reads on one port give one pulse per handshake, in order.
        single_write(0, 48'h8, 64'hA5A5A5A5_A5A5A5A5, 8'hFF, "b2b_wr");
        @(negedge clk);
        applyStimulus(0, 1'b0, 48'h0, '0, '0);
        @(negedge clk);
        checkOutput("b2b_pv0", 64'(p_valid[0]), 64'h1);
        checkOutput("b2b_data0", rsp_data[0], 64'h55);
        applyStimulus(0, 1'b0, 48'h8, '0, '0);
        @(negedge clk);
        idle_all();
        checkOutput("b2b_pv1", 64'(p_valid[0]), 64'h1);
        checkOutput("b2b_data1", rsp_data[0], 64'hA5A5A5A5_A5A5A5A5);
        @(negedge clk);
        checkOutput("b2b_pv_end", 64'(p_valid[0]), 64'h0);

        // Four ports hammer bank 5; grants rotate 0,1,2,3,0,1,2,3.
        for (int p = 0; p < 4; p++) applyStimulus(p, 1'b0, 48'h28, '0, '0);
        for (int c = 0; c < 8; c++) begin
            #1 checkOutput($sformatf("rr_c%0d", c), 64'(q_ready), 64'(16'(1) << (c % 4)));
            @(negedge clk);
        end
        idle_all();

        // Reset right after a read handshake discards the pending response.
        @(negedge clk);
        applyStimulus(0, 1'b0, 48'h0, '0, '0);
        #1 checkOutput("rstmid_rdy", 64'(q_ready[0]), 64'h1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 checkOutput("rstmid_pv", 64'(p_valid), 64'h0);
        idle_all();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rstmid_noreplay", 64'(p_valid), 64'h0);
        applyStimulus(0, 1'b0, 48'h0, '0, '0);
        applyStimulus(1, 1'b0, 48'h100, '0, '0);
        #1 checkOutput("rstmid_arb", 64'(q_ready), 64'h0001);
        @(negedge clk);
        idle_all();
        checkOutput("rstmid_pv_after", 64'(p_valid[0]), 64'h1);
        checkOutput("rstmid_keep", rsp_data[0], 64'h55);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
